// File: rtl/stream_packer.sv
// stream_packer
// Packs PACK_RATIO narrow upstream beats into one wide downstream word.
// Beat k of a word lands in lane k (beat 0 in the LSBs). A packet may end
// early with up_last; the word is then emitted with only the filled lanes,
// upper lanes zeroed, and dn_keep giving the number of valid beats.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   up_bus   in   DATA_WIDTH            upstream beat
//   up_val   in   1                     upstream beat valid
//   up_last  in   1                     final beat of a packet (qualified by up_val)
//   up_rdy   out  1                     block accepts a beat this cycle
//   dn_bus   out  DATA_WIDTH*PACK_RATIO packed word
//   dn_keep  out  clog2(PACK_RATIO+1)   number of valid beats in dn_bus
//   dn_val   out  1                     dn_bus/dn_keep valid
//   dn_rdy   in   1                     downstream accepts the word
module stream_packer #(
    parameter int DATA_WIDTH = 7,
    parameter int PACK_RATIO = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              up_bus,
    input  logic                               up_val,
    input  logic                               up_last,
    output logic                               up_rdy,
    output logic [DATA_WIDTH*PACK_RATIO-1:0]   dn_bus,
    output logic [$clog2(PACK_RATIO+1)-1:0]    dn_keep,
    output logic                               dn_val,
    input  logic                               dn_rdy
);

    localparam int BUS_W  = DATA_WIDTH * PACK_RATIO;
    localparam int CNT_W  = $clog2(PACK_RATIO);
    localparam int KEEP_W = $clog2(PACK_RATIO + 1);

    logic [BUS_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             take;
    logic             completing;
    logic [BUS_W-1:0] merged;

    // Lanes below the current one come from the accumulator, the current
    // lane takes the incoming beat and everything above is forced to zero.
    // The same image serves as the next accumulator for a non-completing
    // beat and as the output word for a completing one.
    function automatic logic [BUS_W-1:0] merge_lanes(
        input logic [BUS_W-1:0]      acc_in,
        input logic [DATA_WIDTH-1:0] beat,
        input logic [CNT_W-1:0]      lane
    );
        logic [BUS_W-1:0] w;
        w = '0;
        for (int l = 0; l < PACK_RATIO; l++) begin
            if (l < int'(lane)) begin
                w[l*DATA_WIDTH +: DATA_WIDTH] = acc_in[l*DATA_WIDTH +: DATA_WIDTH];
            end else if (l == int'(lane)) begin
                w[l*DATA_WIDTH +: DATA_WIDTH] = beat;
            end
        end
        return w;
    endfunction

    // The output register frees up either because it is empty or because
    // it is being drained on this edge; up_val plays no part, so there is
    // no combinational loop through the upstream handshake.
    assign up_rdy = !rst && (!dn_val || dn_rdy);

    always_comb begin
        take       = up_val && up_rdy;
        completing = (cnt == CNT_W'(PACK_RATIO - 1)) || up_last;
        merged     = merge_lanes(acc, up_bus, cnt);
    end

    // Accumulator / output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            dn_bus  <= '0;
            dn_keep <= '0;
            dn_val  <= 1'b0;
        end else begin
            if (take) begin
                if (completing) begin
                    dn_bus  <= merged;
                    dn_keep <= KEEP_W'(cnt) + KEEP_W'(1);
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= merged;
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // A new word loading on a drain edge keeps dn_val high, so
            // back-to-back words need no bubble.
            if (take && completing) begin
                dn_val <= 1'b1;
            end else if (dn_rdy) begin
                dn_val <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// Testbench for stream_packer (DATA_WIDTH=7, PACK_RATIO=4).
// A driver issues directed and random beats; a monitor on the falling edge
// observes handshakes, builds expected words from a queue-based packet
// model and compares every downstream transfer against it.
module tb_stream_packer;

    localparam int DW = 7;
    localparam int PR = 4;
    localparam int BW = DW * PR;
    localparam int KW = $clog2(PR + 1);

    logic          clk;
    logic          rst;
    logic [DW-1:0] up_bus;
    logic          up_val;
    logic          up_last;
    logic          up_rdy;
    logic [BW-1:0] dn_bus;
    logic [KW-1:0] dn_keep;
    logic          dn_val;
    logic          dn_rdy;

    stream_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .clk    (clk),
        .rst    (rst),
        .up_bus (up_bus),
        .up_val (up_val),
        .up_last(up_last),
        .up_rdy (up_rdy),
        .dn_bus (dn_bus),
        .dn_keep(dn_keep),
        .dn_val (dn_val),
        .dn_rdy (dn_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [BW-1:0] bus;
        int            keep;
    } word_t;

    int            tests  = 0;
    int            failed = 0;
    word_t         exp_q[$];
    logic [DW-1:0] partial[$];
    logic [BW-1:0] last_bus  = '0;
    int            last_keep = 0;
    int            words     = 0;
    int            val_cycles = 0;
    bit            rdy_rand  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // ---------------- monitor / reference model ----------------
    bit            hold_prev  = 0;
    bit            expect_val = 0;
    logic [BW-1:0] prev_bus;
    logic [KW-1:0] prev_keep;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_dn_val", {31'd0, dn_val}, 32'd0);
            chk("rst_dn_bus", {4'd0, dn_bus}, 32'd0);
            chk("rst_dn_keep", {29'd0, dn_keep}, 32'd0);
            chk("rst_up_rdy", {31'd0, up_rdy}, 32'd0);
            partial.delete();
            exp_q.delete();
            hold_prev  = 0;
            expect_val = 0;
        end else begin
            chk("up_rdy_rule", {31'd0, up_rdy}, {31'd0, (!dn_val || dn_rdy)});
            if (hold_prev) begin
                chk("stall_bus", {4'd0, dn_bus}, {4'd0, prev_bus});
                chk("stall_keep", {29'd0, dn_keep}, {29'd0, prev_keep});
                chk("stall_val", {31'd0, dn_val}, 32'd1);
            end
            if (expect_val) chk("latency_val", {31'd0, dn_val}, 32'd1);
            expect_val = 0;
            if (dn_val) val_cycles++;
            if (dn_val && dn_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {4'd0, dn_bus}, 32'hFFFF_FFFF);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("word_bus", {4'd0, dn_bus}, {4'd0, w.bus});
                    chk("word_keep", {29'd0, dn_keep}, w.keep);
                end
                last_bus  = dn_bus;
                last_keep = int'(dn_keep);
                words++;
            end
            if (up_val && up_rdy) begin
                partial.push_back(up_bus);
                if (partial.size() == PR || up_last) begin
                    word_t w;
                    w.bus  = '0;
                    w.keep = partial.size();
                    foreach (partial[i]) w.bus = w.bus | (BW'(partial[i]) << (i * DW));
                    exp_q.push_back(w);
                    partial.delete();
                    expect_val = 1;
                end
            end
            hold_prev = dn_val && !dn_rdy;
            prev_bus  = dn_bus;
            prev_keep = dn_keep;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) dn_rdy = ($urandom % 3) != 0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        int  n;
        bit  done;
        logic a;
        n = 0;
        done = 0;
        up_bus  = d;
        up_last = last;
        up_val  = 1'b1;
        while (!done) begin
            @(negedge clk);
            a = up_rdy;
            tick();
            if (a) done = 1;
            else begin
                n++;
                if (n > 200) begin
                    tests++;
                    failed++;
                    $display("FAIL send_timeout: beat %0h not accepted, required acceptance", d);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        up_val  = 1'b0;
        up_last = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        up_val  = 1'b0;
        up_last = 1'b0;
        while ((exp_q.size() != 0 || dn_val) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            tests++;
            failed++;
            $display("FAIL drain_timeout: %0d words pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        int v0, w0;
        rst = 1'b1; up_bus = '0; up_val = 1'b0; up_last = 1'b0; dn_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_up_rdy", {31'd0, up_rdy}, 32'd1);
        chk("post_rst_dn_val", {31'd0, dn_val}, 32'd0);
        tick();

        // full word
        v0 = val_cycles;
        send(7'h01, 0); send(7'h02, 0); send(7'h03, 0); send(7'h04, 0);
        wait_drain();
        chk("full_bus", {4'd0, last_bus}, 32'h080C101);
        chk("full_keep", last_keep, 4);
        chk("full_val_cycles", val_cycles - v0, 1);

        // partial packet followed by a single-beat packet
        send(7'h7F, 0); send(7'h55, 1);
        wait_drain();
        chk("partial_bus", {4'd0, last_bus}, 32'h0002AFF);
        chk("partial_keep", last_keep, 2);
        send(7'h2A, 1);
        wait_drain();
        chk("single_bus", {4'd0, last_bus}, 32'h000002A);
        chk("single_keep", last_keep, 1);

        // backpressure
        dn_rdy = 1'b0;
        w0 = words;
        fork
            begin
                send(7'h30, 0); send(7'h31, 0); send(7'h32, 0); send(7'h33, 0);
                send(7'h40, 1);
            end
            begin
                repeat (8) @(negedge clk);
                chk("bp_up_rdy", {31'd0, up_rdy}, 32'd0);
                chk("bp_dn_val", {31'd0, dn_val}, 32'd1);
                @(posedge clk);
                #1 dn_rdy = 1'b1;
            end
        join
        wait_drain();
        chk("bp_words", words - w0, 2);
        chk("bp_last_bus", {4'd0, last_bus}, 32'h40);

        // back-to-back
        w0 = words;
        for (int i = 0; i < 8; i++) send(7'h10 + 7'(i), 0);
        wait_drain();
        chk("b2b_words", words - w0, 2);
        chk("b2b_lane0", {25'd0, last_bus[DW-1:0]}, 32'h14);

        // reset mid-word
        send(7'h11, 0); send(7'h22, 0);
        up_val = 1'b0;
        rst = 1'b1;
        #1 chk("async_rst_up_rdy", {31'd0, up_rdy}, 32'd0);
        chk("async_rst_bus", {4'd0, dn_bus}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(7'h01, 0); send(7'h02, 0); send(7'h03, 0); send(7'h04, 0);
        wait_drain();
        chk("rst_mid_bus", {4'd0, last_bus}, 32'h080C101);
        chk("rst_mid_keep", last_keep, 4);

        // random traffic with random backpressure
        rdy_rand = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 4 == 0) idle(1 + int'($urandom % 3));
            send(DW'($urandom), ($urandom % 5) == 0);
        end
        send(7'h00, 1);
        rdy_rand = 0;
        dn_rdy = 1'b1;
        wait_drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
